// File: rtl/int_exec_unit_pkg.sv
// Shared opcode encodings, FSM state type and decode helpers for the integer execute stage.
// Optional flush support elsewhere is enabled by defining INT_EXEC_FLUSH_EN.
package int_exec_unit_pkg;

  localparam int unsigned CNT_W = 3;

  localparam logic [4:0] OP_ADD   = 5'h00;
  localparam logic [4:0] OP_SUB   = 5'h01;
  localparam logic [4:0] OP_SLL   = 5'h02;
  localparam logic [4:0] OP_SLT   = 5'h03;
  localparam logic [4:0] OP_SLTU  = 5'h04;
  localparam logic [4:0] OP_XOR   = 5'h05;
  localparam logic [4:0] OP_SRL   = 5'h06;
  localparam logic [4:0] OP_SRA   = 5'h07;
  localparam logic [4:0] OP_OR    = 5'h08;
  localparam logic [4:0] OP_AND   = 5'h09;
  localparam logic [4:0] OP_MUL   = 5'h0A;
  localparam logic [4:0] OP_MULH  = 5'h0B;
  localparam logic [4:0] OP_MULHU = 5'h0C;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

  function automatic logic is_mul_op(input logic [4:0] opc);
    return (opc == OP_MUL) || (opc == OP_MULH) || (opc == OP_MULHU);
  endfunction

endpackage

// File: rtl/int_exec_unit_if.sv
// Issue-side and CDB-side handshake bundle of the integer execute stage.
// The flush signal exists only when INT_EXEC_FLUSH_EN is defined.
interface int_exec_unit_if;

  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_opcode;
  logic [5:0]  issue_rd_tag;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  logic        cdb_req;
  logic        cdb_grant;
  logic [31:0] cdb_data;
  logic [5:0]  cdb_tag;
`ifdef INT_EXEC_FLUSH_EN
  logic        flush;
`endif

  modport master (
`ifdef INT_EXEC_FLUSH_EN
    output flush,
`endif
    output issue_valid, issue_opcode, issue_rd_tag, issue_rs1, issue_rs2, cdb_grant,
    input  issue_ready, cdb_req, cdb_data, cdb_tag
  );

  modport slave (
`ifdef INT_EXEC_FLUSH_EN
    input  flush,
`endif
    input  issue_valid, issue_opcode, issue_rd_tag, issue_rs1, issue_rs2, cdb_grant,
    output issue_ready, cdb_req, cdb_data, cdb_tag
  );

endinterface

// File: rtl/int_exec_unit_mul_pipe.sv
// Multiplier for MUL/MULH/MULHU: latched operands, registered product and a
// LATENCY-deep valid chain that freezes while hold is asserted.
module int_exec_unit_mul_pipe
  import int_exec_unit_pkg::*;
#(
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        kill,
  input  logic        hold,
  input  logic [4:0]  opcode,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        valid,
  output logic [31:0] result
);

  logic [31:0]        a_q, a_d, b_q, b_d, prod_q, prod_d;
  logic               sgn_q, sgn_d, hi_q, hi_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [63:0]        a_ext_s, b_ext_s, full_s;

  // Operand capture, 64-bit two's-complement product and valid chain advance.
  always_comb begin
    if (start) begin
      a_d   = rs1;
      b_d   = rs2;
      sgn_d = (opcode == OP_MULH);
      hi_d  = (opcode != OP_MUL);
    end else begin
      a_d   = a_q;
      b_d   = b_q;
      sgn_d = sgn_q;
      hi_d  = hi_q;
    end
    a_ext_s = {{32{sgn_q & a_q[31]}}, a_q};
    b_ext_s = {{32{sgn_q & b_q[31]}}, b_q};
    full_s  = a_ext_s * b_ext_s;
    prod_d  = hi_q ? full_s[63:32] : full_s[31:0];
    if (kill) begin
      vld_d = '0;
    end else if (hold) begin
      vld_d = vld_q;
    end else begin
      vld_d = {vld_q[LATENCY-2:0], start};
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= 32'h0;
      b_q    <= 32'h0;
      sgn_q  <= 1'b0;
      hi_q   <= 1'b0;
      prod_q <= 32'h0;
      vld_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      sgn_q  <= sgn_d;
      hi_q   <= hi_d;
      prod_q <= prod_d;
      vld_q  <= vld_d;
    end
  end

  assign valid  = vld_q[LATENCY-1];
  assign result = prod_q;

endmodule

// File: rtl/int_exec_unit.sv
// Integer execute stage: 1-cycle ALU, multi-cycle multiplier, CDB result register.
// Define INT_EXEC_FLUSH_EN to add the flush input that kills all in-flight work.
module int_exec_unit
  import int_exec_unit_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 3
) (
  input logic            clk,
  input logic            reset,
  int_exec_unit_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cdb_req_q, cdb_req_d;
  logic [31:0]       cdb_data_q, cdb_data_d;
  logic [5:0]        cdb_tag_q, cdb_tag_d;
  logic [5:0]        mul_tag_q, mul_tag_d;
  logic              flush_s, free_s, ready_s, accept_s, mul_start_s, mul_hold_s;
  logic              mul_valid_s;
  logic [31:0]       mul_result_s, alu_s;
  logic [4:0]        shamt_s;

`ifdef INT_EXEC_FLUSH_EN
  assign flush_s = bus.flush;
`else
  assign flush_s = 1'b0;
`endif

  // Handshake: a grant frees the result slot in the same cycle.
  always_comb begin
    free_s      = !cdb_req_q | bus.cdb_grant;
    ready_s     = (state_q == IDLE) & free_s & !flush_s;
    accept_s    = bus.issue_valid & ready_s;
    mul_start_s = accept_s & is_mul_op(bus.issue_opcode);
    mul_hold_s  = (state_q == MUL_BUSY) & (cnt_q == {CNT_W{1'b0}}) & !free_s;
  end

  // Single-cycle ALU; MUL-class and undefined opcodes yield zero here.
  always_comb begin
    shamt_s = bus.issue_rs2[4:0];
    case (bus.issue_opcode)
      OP_ADD:  alu_s = bus.issue_rs1 + bus.issue_rs2;
      OP_SUB:  alu_s = bus.issue_rs1 - bus.issue_rs2;
      OP_SLL:  alu_s = bus.issue_rs1 << shamt_s;
      OP_SLT:  alu_s = ($signed(bus.issue_rs1) < $signed(bus.issue_rs2)) ? 32'h1 : 32'h0;
      OP_SLTU: alu_s = (bus.issue_rs1 < bus.issue_rs2) ? 32'h1 : 32'h0;
      OP_XOR:  alu_s = bus.issue_rs1 ^ bus.issue_rs2;
      OP_SRL:  alu_s = bus.issue_rs1 >> shamt_s;
      OP_SRA:  alu_s = $signed(bus.issue_rs1) >>> shamt_s;
      OP_OR:   alu_s = bus.issue_rs1 | bus.issue_rs2;
      OP_AND:  alu_s = bus.issue_rs1 & bus.issue_rs2;
      default: alu_s = 32'h0;
    endcase
  end

  // FSM and result register next state; flush overrides grant and load.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cdb_req_d  = cdb_req_q & !bus.cdb_grant;
    cdb_data_d = cdb_data_q;
    cdb_tag_d  = cdb_tag_q;
    mul_tag_d  = mul_tag_q;
    if (flush_s) begin
      state_d   = IDLE;
      cdb_req_d = 1'b0;
      cnt_d     = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (mul_start_s) begin
            state_d   = MUL_BUSY;
            cnt_d     = CNT_W'(MUL_LATENCY - 1);
            mul_tag_d = bus.issue_rd_tag;
          end else if (accept_s) begin
            cdb_req_d  = 1'b1;
            cdb_data_d = alu_s;
            cdb_tag_d  = bus.issue_rd_tag;
          end else begin
            state_d = IDLE;
          end
        end
        MUL_BUSY: begin
          if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (free_s & mul_valid_s) begin
            state_d    = IDLE;
            cdb_req_d  = 1'b1;
            cdb_data_d = mul_result_s;
            cdb_tag_d  = mul_tag_q;
          end else begin
            state_d = MUL_BUSY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counter and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      cdb_req_q  <= 1'b0;
      cdb_data_q <= 32'h0;
      cdb_tag_q  <= 6'h0;
      mul_tag_q  <= 6'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cdb_req_q  <= cdb_req_d;
      cdb_data_q <= cdb_data_d;
      cdb_tag_q  <= cdb_tag_d;
      mul_tag_q  <= mul_tag_d;
    end
  end

  int_exec_unit_mul_pipe #(.LATENCY(MUL_LATENCY)) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start_s),
    .kill   (flush_s),
    .hold   (mul_hold_s),
    .opcode (bus.issue_opcode),
    .rs1    (bus.issue_rs1),
    .rs2    (bus.issue_rs2),
    .valid  (mul_valid_s),
    .result (mul_result_s)
  );

  assign bus.issue_ready = ready_s;
  assign bus.cdb_req     = cdb_req_q;
  assign bus.cdb_data    = cdb_data_q;
  assign bus.cdb_tag     = cdb_tag_q;

endmodule
